opll_write_sequencer: RTL and testbench

//  Queues CPU/host register writes (addr,data pairs) and replays them onto the OPLL core's
//  bus port (D, A0, WR_n, CS_n) with the chip's mandatory address/data wait spacing.

---
 rtl/opll_bus_pkg.sv | 38 +++
 rtl/opll_wr_fifo.sv | 58 +++++
 rtl/opll_write_sequencer.sv | 145 ++++++++++++++
 tb/tb_opll_write_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opll_bus_pkg.sv
// Shared types and default timing constants for the OPLL bus write sequencer.
`default_nettype none

package opll_bus_pkg;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_WR_PULSE   = 4;
  localparam int DEF_ADDR_WAIT  = 12;
  localparam int DEF_DATA_WAIT  = 84;
  localparam int DEF_INIT_WAIT  = 1024;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ADDR_WR  = 3'd2,
    ST_ADDR_GAP = 3'd3,
    ST_DATA_WR  = 3'd4,
    ST_DATA_GAP = 3'd5
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } pair_t;

  // Counter width large enough for (longest wait - 1); never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/opll_wr_fifo.sv
// Synchronous FIFO of (addr,data) pairs with occupancy level; head is read combinationally.
`default_nettype none

module opll_wr_fifo
  import opll_bus_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  pair_t                    wdata,
  output pair_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  pair_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/opll_write_sequencer.sv
// Queues host register writes and replays them as spaced address/data strobes on the OPLL bus.
`default_nettype none

module opll_write_sequencer
  import opll_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WR_PULSE   = DEF_WR_PULSE,
  parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
  parameter int DATA_WAIT  = DEF_DATA_WAIT,
  parameter int INIT_WAIT  = DEF_INIT_WAIT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [7:0]                    req_addr,
  input  logic [7:0]                    req_data,
  output logic [7:0]                    o_D,
  output logic                          o_A0,
  output logic                          o_WR_n,
  output logic                          o_CS_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = cnt_width(INIT_WAIT, DATA_WAIT, ADDR_WAIT, WR_PULSE);
  localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_AGAP  = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_DGAP  = CNT_W'(DATA_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  pair_t            head;
  pair_t            hold;
  pair_t            wpair;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             cnt_zero;

  assign cnt_zero  = (cnt == '0);
  assign req_ready = rst_n && !full;
  assign push      = req_valid && req_ready;
  assign pop       = !empty &&
                     ((state == ST_IDLE) || ((state == ST_DATA_GAP) && cnt_zero));
  assign busy      = rst_n && (!empty || !((state == ST_IDLE) || (state == ST_INIT)));
  assign wpair     = '{addr: req_addr, data: req_data};

  opll_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wpair),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Strobe follows the state register by one cycle, so D/A0 (set on *_WR entry)
  // lead the falling edge by a full cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      cnt    <= LD_INIT;
      hold   <= '0;
      o_D    <= '0;
      o_A0   <= 1'b0;
      o_WR_n <= 1'b1;
      o_CS_n <= 1'b1;
    end else begin
      o_WR_n <= !((state == ST_ADDR_WR) || (state == ST_DATA_WR));
      o_CS_n <= !((state == ST_ADDR_WR) || (state == ST_DATA_WR));
      case (state)
        ST_INIT: begin
          if (cnt_zero) state <= ST_IDLE;
          else          cnt   <= cnt - 1'b1;
        end
        ST_IDLE: begin
          if (pop) begin
            hold  <= head;
            o_D   <= head.addr;
            o_A0  <= 1'b0;
            cnt   <= LD_PULSE;
            state <= ST_ADDR_WR;
          end
        end
        ST_ADDR_WR: begin
          if (cnt_zero) begin
            cnt   <= LD_AGAP;
            state <= ST_ADDR_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ADDR_GAP: begin
          if (cnt_zero) begin
            o_D   <= hold.data;
            o_A0  <= 1'b1;
            cnt   <= LD_PULSE;
            state <= ST_DATA_WR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA_WR: begin
          if (cnt_zero) begin
            cnt   <= LD_DGAP;
            state <= ST_DATA_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA_GAP: begin
          if (cnt_zero) begin
            if (pop) begin
              hold  <= head;
              o_D   <= head.addr;
              o_A0  <= 1'b0;
              cnt   <= LD_PULSE;
              state <= ST_ADDR_WR;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          cnt   <= LD_INIT;
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_opll_write_sequencer.sv
// Randomized bench for opll_write_sequencer against a pair-schedule reference model.
`default_nettype none

module tb_opll_write_sequencer;

  localparam int DEPTH  = 4;
  localparam int WP     = 4;
  localparam int AW     = 12;
  localparam int DW     = 84;
  localparam int IW     = 1024;
  localparam int PERIOD = 2*WP + AW + DW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic [7:0] o_D;
  logic       o_A0;
  logic       o_WR_n;
  logic       o_CS_n;
  logic       busy;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  opll_write_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .WR_PULSE   (WP),
    .ADDR_WAIT  (AW),
    .DATA_WAIT  (DW),
    .INIT_WAIT  (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .o_D        (o_D),
    .o_A0       (o_A0),
    .o_WR_n     (o_WR_n),
    .o_CS_n     (o_CS_n),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: accepted pairs wait in q; a pair popped at edge P drives the
  // address strobe after edges P+1..P+WP and the data strobe after P+WP+AW+1..P+2WP+AW.
  logic [15:0] q[$];
  int          avail = 0;
  int          pop_edge = 0;
  bit          have_pop = 0;
  logic [7:0]  cur_a = '0;
  logic [7:0]  cur_d = '0;

  bit          prev_wr = 1'b1;
  logic [7:0]  prev_d = '0;
  bit          prev_a0 = 1'b0;
  bit          seen_rise = 1'b0;
  int          last_rise = 0;
  bit          last_a0 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_outputs();
    int         t;
    bit         exp_low;
    logic [7:0] exp_d;
    bit         exp_a0;
    bit         exp_busy;
    t        = cyc - pop_edge;
    exp_low  = have_pop && ((t >= 1 && t <= WP) || (t >= WP+AW+1 && t <= 2*WP+AW));
    exp_d    = !have_pop ? 8'h00 : ((t < WP+AW) ? cur_a : cur_d);
    exp_a0   = have_pop && (t >= WP+AW);
    exp_busy = rst_n && ((q.size() > 0) || (have_pop && t < PERIOD));
    check_eq("wr_n", o_WR_n, !exp_low);
    check_eq("cs_n", o_CS_n, !exp_low);
    check_eq("d", o_D, exp_d);
    check_eq("a0", o_A0, exp_a0);
    check_eq("busy", busy, exp_busy);
    check_eq("level", fifo_level, q.size());
    // Independent bus-protocol watch: spacing and data stability around strobes.
    if (!o_WR_n && prev_wr && seen_rise)
      check_eq("strobe_gap_ok", ((cyc - last_rise) >= (last_a0 ? DW : AW)), 1);
    if (o_WR_n && !prev_wr) begin
      last_rise = cyc;
      last_a0   = prev_a0;
      seen_rise = 1'b1;
    end
    if (!o_WR_n && !prev_wr) begin
      check_eq("d_hold", o_D, prev_d);
      check_eq("a0_hold", o_A0, prev_a0);
    end
    if (!rst_n) seen_rise = 1'b0;
    prev_wr = o_WR_n;
    prev_d  = o_D;
    prev_a0 = o_A0;
  endtask

  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] d,
                      input bit rn, output bit acc);
    bit exp_ready;
    rst_n     = rn;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    #1;
    exp_ready = rn && (q.size() < DEPTH);
    check_eq("req_ready", req_ready, exp_ready);
    @(posedge clk);
    cyc++;
    acc = 1'b0;
    if (!rn) begin
      q.delete();
      have_pop = 1'b0;
      avail    = cyc + IW + 1;
    end else begin
      if (q.size() > 0 && cyc >= avail) begin
        {cur_a, cur_d} = q.pop_front();
        pop_edge = cyc;
        have_pop = 1'b1;
        avail    = cyc + PERIOD;
      end
      if (v && exp_ready) begin
        q.push_back({a, d});
        acc = 1'b1;
      end
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b1, acc);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, acc);
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 600) begin
      step(1'b1, a, d, 1'b1, acc);
      n++;
    end
    check_eq("push_accepted", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || (have_pop && (cyc - pop_edge) < PERIOD)) && n < 2000) begin
      idle(1);
      n++;
    end
    idle(2);
    check_eq("drained_busy", busy, 0);
  endtask

  initial begin
    bit acc;
    int n;

    // Reset state, then a single write well after INIT.
    do_reset(3);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_wr_n", o_WR_n, 1);
    idle(IW + 10);
    push_pair(8'h10, 8'h55);
    drain();

    // Request queued during INIT.
    do_reset(3);
    idle(5);
    push_pair(8'($urandom), 8'($urandom));
    drain();

    // Six back-to-back pairs into a four-deep FIFO.
    for (int i = 0; i < 6; i++) push_pair(8'($urandom), 8'($urandom));
    drain();

    // Push coinciding with a pop while one entry is queued.
    push_pair(8'hA1, 8'h11);
    push_pair(8'hA2, 8'h22);
    n = 0;
    while (!(q.size() == 1 && cyc + 1 >= avail) && n < 400) begin
      idle(1);
      n++;
    end
    step(1'b1, 8'hA3, 8'h33, 1'b1, acc);
    check_eq("pushpop_accept", acc, 1);
    check_eq("pushpop_level", fifo_level, 1);
    drain();

    // Reset in the middle of the data strobe.
    push_pair(8'h3C, 8'hC3);
    n = 0;
    while (!(have_pop && (cyc - pop_edge) == WP + AW + 2) && n < 400) begin
      idle(1);
      n++;
    end
    check_eq("mid_data_strobe", o_WR_n, 0);
    step(1'b0, 8'h00, 8'h00, 1'b0, acc);
    check_eq("abort_wr_n", o_WR_n, 1);
    check_eq("abort_d", o_D, 0);
    check_eq("abort_level", fifo_level, 0);
    idle(IW + 20);
    push_pair(8'h44, 8'h99);
    drain();

    // Random traffic, frequent enough to saturate the FIFO.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 19) == 0), 8'($urandom), 8'($urandom), 1'b1, acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
